control_pipeline: RTL and testbench

CONTROL_PIPELINE -- requirements
Module: control_pipeline

---
 rtl/control_pipeline.sv | 93 +++++++++
 tb/tb_control_pipeline.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline.sv
// Control-word pipeline EX -> MEM -> WB with load-use stall detection and flush.
// Optional load-use stall counter is enabled by defining CTRL_PIPELINE_STALL_CNT_EN.
module control_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  id_ctrl,
  input  logic        id_valid,
  input  logic [3:0]  id_rd,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        flush,
  output logic        stall,
  output logic [3:0]  ex_alu_op,
  output logic        ex_valid,
  output logic        mem_we,
  output logic        mem_valid,
  output logic        wb_wre,
  output logic [1:0]  wb_sel,
  output logic [3:0]  wb_rd,
  output logic        wb_valid,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic [7:0] ctrl;
    logic [3:0] rd;
    logic       valid;
  } slot_t;

  localparam slot_t BUBBLE = '{ctrl: 8'h00, rd: 4'h0, valid: 1'b0};

  slot_t ex_reg, mem_reg, wb_reg;
  slot_t ex_next;
  logic  ex_is_load;
  logic  rs_match;

  // A load writes the register file from memory: wre set, no store, select 00.
  assign ex_is_load = ex_reg.valid & ex_reg.ctrl[7] & ~ex_reg.ctrl[6] &
                      (ex_reg.ctrl[5:4] == 2'b00);
  assign rs_match   = (ex_reg.rd == id_rs1) | (ex_reg.rd == id_rs2);
  assign stall      = id_valid & ~flush & ex_is_load & rs_match;

  always_comb begin
    ex_next = BUBBLE;
    if (id_valid && !flush && !stall) begin
      ex_next.ctrl  = id_ctrl;
      ex_next.rd    = id_rd;
      ex_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg  <= BUBBLE;
      mem_reg <= BUBBLE;
      wb_reg  <= BUBBLE;
    end else begin
      ex_reg  <= ex_next;
      mem_reg <= ex_reg;
      wb_reg  <= mem_reg;
    end
  end

  assign ex_alu_op = ex_reg.ctrl[3:0];
  assign ex_valid  = ex_reg.valid;
  assign mem_we    = mem_reg.ctrl[6] & mem_reg.valid;
  assign mem_valid = mem_reg.valid;
  assign wb_wre    = wb_reg.ctrl[7] & wb_reg.valid;
  assign wb_sel    = wb_reg.ctrl[5:4];
  assign wb_rd     = wb_reg.rd;
  assign wb_valid  = wb_reg.valid;

  // WB keeps the whole control word; only the writeback fields leave the block.
  logic unused_wb_bits;
  assign unused_wb_bits = ^{wb_reg.ctrl[6], wb_reg.ctrl[3:0]};

`ifdef CTRL_PIPELINE_STALL_CNT_EN
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_reg <= 16'h0000;
    end else if (stall && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_count = stall_count_reg;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: scoreboard of issued instructions checked per stage each cycle.
module tb_control_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  id_ctrl;
  logic        id_valid;
  logic [3:0]  id_rd;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic        flush;
  logic        stall;
  logic [3:0]  ex_alu_op;
  logic        ex_valid;
  logic        mem_we;
  logic        mem_valid;
  logic        wb_wre;
  logic [1:0]  wb_sel;
  logic [3:0]  wb_rd;
  logic        wb_valid;
  logic [15:0] stall_count;

  control_pipeline dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_ctrl     (id_ctrl),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .stall       (stall),
    .ex_alu_op   (ex_alu_op),
    .ex_valid    (ex_valid),
    .mem_we      (mem_we),
    .mem_valid   (mem_valid),
    .wb_wre      (wb_wre),
    .wb_sel      (wb_sel),
    .wb_rd       (wb_rd),
    .wb_valid    (wb_valid),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] ctrl;
    logic [3:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'h0000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one edge, then compare every stage against the scoreboard.
  task automatic tick();
    logic [7:0] exc, memc, wbc;
    logic [3:0] wbr;
    logic       exv, memv, wbv;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due + 2 < cyc) void'(sb.pop_front());
    exc = 8'h00; memc = 8'h00; wbc = 8'h00; wbr = 4'h0;
    exv = 1'b0;  memv = 1'b0;  wbv = 1'b0;
    foreach (sb[i]) begin
      if (sb[i].due == cyc)     begin exv = 1'b1;  exc = sb[i].ctrl; end
      if (sb[i].due + 1 == cyc) begin memv = 1'b1; memc = sb[i].ctrl; end
      if (sb[i].due + 2 == cyc) begin wbv = 1'b1;  wbc = sb[i].ctrl; wbr = sb[i].rd; end
    end
    check("ex_valid",  {15'd0, ex_valid},  {15'd0, exv});
    check("ex_alu_op", {12'd0, ex_alu_op}, {12'd0, exc[3:0]});
    check("mem_valid", {15'd0, mem_valid}, {15'd0, memv});
    check("mem_we",    {15'd0, mem_we},    {15'd0, memc[6]});
    check("wb_valid",  {15'd0, wb_valid},  {15'd0, wbv});
    check("wb_wre",    {15'd0, wb_wre},    {15'd0, wbc[7]});
    check("wb_sel",    {14'd0, wb_sel},    {14'd0, wbc[5:4]});
    check("wb_rd",     {12'd0, wb_rd},     {12'd0, wbr});
  endtask

  // Present a decode-stage instruction, check stall and the counter, record it if accepted.
  task automatic drive(input logic [7:0] c, input logic v, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic fl,
                       input logic exp_stall);
    id_ctrl = c; id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; flush = fl;
    #1;
    check("stall", {15'd0, stall}, {15'd0, exp_stall});
    check("stall_count", stall_count, exp_cnt);
    if (v && !fl && !exp_stall) sb.push_back('{due: cyc + 1, ctrl: c, rd: rd});
`ifdef CTRL_PIPELINE_STALL_CNT_EN
    if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Reset state, held across edges.
    rst_n = 1'b0;
    id_ctrl = 8'h91; id_valid = 1'b1; id_rd = 4'h3; id_rs1 = 4'h0; id_rs2 = 4'h0; flush = 1'b0;
    #1;
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_stall_count", stall_count, 16'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;

    // Add with no hazard: EX at +1, WB write of rd=3 via select 01 at +3.
    drive(8'h91, 1'b1, 4'h3, 4'h1, 4'h2, 1'b0, 1'b0); tick();
    idle(4);

    // Load-use on rs1: one stall cycle, bubble in EX, add reaches WB at +5.
    drive(8'h81, 1'b1, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'h91, 1'b1, 4'h6, 4'h5, 4'h0, 1'b0, 1'b1); tick();
    drive(8'h91, 1'b1, 4'h6, 4'h5, 4'h0, 1'b0, 1'b0); tick();
    idle(4);

    // Load-use on rs2.
    drive(8'h81, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'h92, 1'b1, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1); tick();
    drive(8'h92, 1'b1, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0); tick();
    idle(3);

    // Store: mem_we only at +2, no register write.
    drive(8'h40, 1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    idle(4);

    // Flush beats stall; then a flush with no hazard.
    drive(8'h81, 1'b1, 4'h9, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'h91, 1'b1, 4'h4, 4'h9, 4'h0, 1'b1, 1'b0); tick();
    drive(8'h93, 1'b1, 4'hA, 4'h0, 4'h0, 1'b1, 1'b0); tick();
    idle(3);

    // Non-load producer never stalls; invalid consumer never stalls.
    drive(8'hA2, 1'b1, 4'hB, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'h91, 1'b1, 4'hC, 4'hB, 4'hB, 1'b0, 1'b0); tick();
    drive(8'h81, 1'b1, 4'hD, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'h91, 1'b0, 4'hE, 4'hD, 4'hD, 1'b0, 1'b0); tick();
    idle(3);

    // Nop with valid travels as a valid slot with all enables low.
    drive(8'h00, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    idle(3);

    // Back-to-back mix fills all three slots, then async reset between edges.
    drive(8'h91, 1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'h40, 1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'hC3, 1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    drive(8'hB5, 1'b1, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_ex_valid",  {15'd0, ex_valid},  16'd0);
    check("async_ex_alu_op", {12'd0, ex_alu_op}, 16'd0);
    check("async_mem_valid", {15'd0, mem_valid}, 16'd0);
    check("async_mem_we",    {15'd0, mem_we},    16'd0);
    check("async_wb_valid",  {15'd0, wb_valid},  16'd0);
    check("async_wb_wre",    {15'd0, wb_wre},    16'd0);
    check("async_wb_sel",    {14'd0, wb_sel},    16'd0);
    check("async_wb_rd",     {12'd0, wb_rd},     16'd0);
    check("async_stall",     {15'd0, stall},     16'd0);
    check("async_stall_count", stall_count, 16'd0);
    sb.delete();
    exp_cnt = 16'h0000;
    tick();
    #2 rst_n = 1'b1;
    drive(8'h91, 1'b1, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    idle(3);

`ifdef CTRL_PIPELINE_STALL_CNT_EN
    // Preload the counter near its ceiling, then stall past it.
    force dut.stall_count_reg = 16'hFFFE;
    #1;
    release dut.stall_count_reg;
    exp_cnt = 16'hFFFE;
    repeat (3) begin
      drive(8'h81, 1'b1, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0); tick();
      drive(8'h91, 1'b1, 4'h6, 4'h5, 4'h0, 1'b0, 1'b1); tick();
      drive(8'h91, 1'b1, 4'h6, 4'h5, 4'h0, 1'b0, 1'b0); tick();
    end
    idle(3);
    check("sat_stall_count", stall_count, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
